contatore_updown_mod: RTL and testbench
=======================================

// Module: contatore_updown_mod
//
// PURPOSE
//  Parametrised Moore up/down counter with programmable modulus, synchronous load/clear,
//  and wrap or saturate mode at the range boundaries.
//  Outputs are functions of registered state only; flags are registered.
//  Used as the generic counting element (dividers, event counters, index generators) in
//  the sequential labs; supersedes the fixed 2-bit increment-by-input counter.
//
// PARAMETERS
//  N         4       counter width in bits (N >= 1)
//  MODULO    2**N    count range 0..MODULO-1; legal 2..2**N
//  SATURATE  0       0 = wrap at boundaries, 1 = hold at boundaries
//
// PORTS
//  clock     in   1   single clock, all state updates on posedge
//  reset_n   in   1   synchronous reset, active-low
//  clear     in   1   synchronous clear to 0, also clears ovf
//  load      in   1   synchronous load of load_val
//  load_val  in   N   value to load; values >= MODULO are clamped to MODULO-1
//  en        in   1   count enable: one step per cycle while high
//  up        in   1   direction: 1 = +1, 0 = -1; sampled only when the counter steps
//  out       out  N   current count (state register, Moore)
//  at_max    out  1   1 iff out == MODULO-1 (decoded from state)
//  at_min    out  1   1 iff out == 0 (decoded from state)
//  ovf       out  1   sticky: set when a step crosses or hits a boundary
//
// BEHAVIOUR
//  - State: s[N-1:0], ovf register. out = s. at_max/at_min are decoded from s only,
//    never from the inputs.
//  - Reset: reset_n==0 at posedge gives s=0, ovf=0, so out=0, at_min=1, at_max=0.
//    Reset dominates all other inputs. A reset asserted mid-count takes effect at the
//    next edge; the count does not resume from the old value.
//  - Per-edge priority when reset_n==1: clear > load > en > hold.
//    - clear:       s<=0, ovf<=0
//    - load:        s <= (load_val >= MODULO) ? MODULO-1 : load_val; ovf unchanged
//    - en & up:     if s==MODULO-1, then s<=(SATURATE ? s : 0) and ovf<=1; else s<=s+1
//    - en & !up:    if s==0, then s<=(SATURATE ? 0 : MODULO-1) and ovf<=1; else s<=s-1
//    - none:        s, ovf hold
//  - Latency: every change is visible on out one cycle after the sampling edge.
//    No combinational path exists from any input to any output.
//  - Arithmetic: compute next state in N+1 bits and compare against MODULO before
//    truncating. The result must be correct when MODULO==2**N, with no reliance on
//    implicit N-bit overflow.
//  - ovf is sticky: it stays 1 until clear or reset. It is set on the boundary step
//    in both modes, including when SATURATE holds the value.
//  - Simultaneous events:
//    - clear with load/en: clear wins.
//    - load with en: load wins, and no step occurs that cycle.
//    - up toggling while en==0 has no effect.
//  - Non-power-of-2 MODULO: states >= MODULO are unreachable from reset. Recovery is
//    only via reset/clear/load.
//
// TESTING
//  1. N=4, MODULO=16, SATURATE=0: reset, en=1 up=1 for 17 edges.
//     Expect out 1..15, 0, 1; at_max only when out==15; ovf=1 from edge 16 onward.
//  2. N=4, MODULO=10, SATURATE=0: load 9, then en up for 1 edge, then en down for 1 edge.
//     Expect out 9, then 0 (ovf=1), then 9 (wrap down).
//  3. N=4, MODULO=10, SATURATE=1: load 12, then en up for 3 edges.
//     Expect out 9 after load (clamp) and out held at 9 with ovf=1. Then en down from
//     load 0: out stays 0.
//  4. Priority: in one cycle clear=1, load=1 (load_val 5), en=1 gives out 0, ovf 0.
//     Next cycle load=1 (load_val 5), en=1, up=1 gives out 5, not 6.
//  5. Reset mid-operation: count to 7, drop reset_n for 1 edge with en=1.
//     Expect out 0, ovf 0. After release, counting resumes 1, 2, ...
//  6. en=0 for 5 edges with up toggling: out and flags constant.
//     Verify no input-to-output combinational change within a cycle.

Source files
------------

// File: rtl/contatore_updown_mod_if.sv
// Bus for contatore_updown_mod: control inputs toward the counter and the
// registered count/flags back.
//   master: drives clear, load, load_val, en, up; reads out, at_max, at_min, ovf
//   slave : the counter side (mirror of master)
interface contatore_updown_mod_if #(
  parameter int N = 4
);
  logic         clear;
  logic         load;
  logic [N-1:0] load_val;
  logic         en;
  logic         up;
  logic [N-1:0] out;
  logic         at_max;
  logic         at_min;
  logic         ovf;

  modport master (
    output clear, load, load_val, en, up,
    input  out, at_max, at_min, ovf
  );

  modport slave (
    input  clear, load, load_val, en, up,
    output out, at_max, at_min, ovf
  );
endinterface

// File: rtl/contatore_updown_mod.sv
// Moore up/down counter, range 0..MODULO-1, wrap or saturate at the ends.
// Ports:
//   clock   : posedge clock for all state
//   reset_n : synchronous active-low reset (s=0, ovf=0), dominates everything
//   bus     : slave side of contatore_updown_mod_if
//             clear > load > en step > hold, evaluated each edge
//             out = count, at_max/at_min decoded from the count, ovf sticky
// All outputs come from registers or decode of registers only.
module contatore_updown_mod #(
  parameter int N        = 4,
  parameter int MODULO   = 2 ** N,
  parameter bit SATURATE = 1'b0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  contatore_updown_mod_if.slave     bus
);

  // Range math is done in N+1 bits so MODULO == 2**N is representable.
  localparam logic [N:0] MOD  = (N+1)'(MODULO);
  localparam logic [N:0] MAXV = (N+1)'(MODULO - 1);

  logic [N-1:0] s, s_nxt;
  logic         ovf, ovf_nxt;
  logic [N:0]   s_ext, inc, dec, lv_ext;

  assign s_ext  = {1'b0, s};
  assign inc    = s_ext + 1'b1;
  assign dec    = s_ext - 1'b1;
  assign lv_ext = {1'b0, bus.load_val};

  always_comb begin
    s_nxt   = s;
    ovf_nxt = ovf;
    if (bus.clear) begin
      s_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (bus.load) begin
      // out-of-range loads clamp to the top of the range
      s_nxt = (lv_ext >= MOD) ? MAXV[N-1:0] : bus.load_val;
    end else if (bus.en) begin
      if (bus.up) begin
        // stepping past MODULO-1 is the boundary hit
        if (inc >= MOD) begin
          s_nxt   = SATURATE ? s : '0;
          ovf_nxt = 1'b1;
        end else begin
          s_nxt = inc[N-1:0];
        end
      end else begin
        // borrow out of the extended subtract means s was 0
        if (dec[N]) begin
          s_nxt   = SATURATE ? '0 : MAXV[N-1:0];
          ovf_nxt = 1'b1;
        end else begin
          s_nxt = dec[N-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s   <= '0;
      ovf <= 1'b0;
    end else begin
      s   <= s_nxt;
      ovf <= ovf_nxt;
    end
  end

  assign bus.out    = s;
  assign bus.at_max = (s_ext == MAXV);
  assign bus.at_min = (s == '0);
  assign bus.ovf    = ovf;

endmodule

// File: tb/tb_contatore_updown_mod.sv
// Directed bench: three counters (mod 16 wrap, mod 10 wrap, mod 10 saturate).
module tb_contatore_updown_mod;
  logic clk = 1'b0;
  logic reset_n;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  contatore_updown_mod_if #(.N(4)) b16 ();
  contatore_updown_mod_if #(.N(4)) b10w ();
  contatore_updown_mod_if #(.N(4)) b10s ();

  contatore_updown_mod #(.N(4), .MODULO(16), .SATURATE(1'b0)) u16 (
    .clock(clk), .reset_n(reset_n), .bus(b16.slave));
  contatore_updown_mod #(.N(4), .MODULO(10), .SATURATE(1'b0)) u10w (
    .clock(clk), .reset_n(reset_n), .bus(b10w.slave));
  contatore_updown_mod #(.N(4), .MODULO(10), .SATURATE(1'b1)) u10s (
    .clock(clk), .reset_n(reset_n), .bus(b10s.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    b16.clear = 0;  b16.load = 0;  b16.load_val = '0;  b16.en = 0;  b16.up = 0;
    b10w.clear = 0; b10w.load = 0; b10w.load_val = '0; b10w.en = 0; b10w.up = 0;
    b10s.clear = 0; b10s.load = 0; b10s.load_val = '0; b10s.en = 0; b10s.up = 0;
    step(); step();
    chk("rst_out", 32'(b16.out), 0);
    chk("rst_min", 32'(b16.at_min), 1);
    chk("rst_max", 32'(b16.at_max), 0);
    chk("rst_ovf", 32'(b16.ovf), 0);
    chk("rst_out10", 32'(b10s.out), 0);
    reset_n = 1'b1;

    // 1: mod-16 wrap, 17 up steps
    b16.en = 1; b16.up = 1;
    for (int i = 1; i <= 17; i++) begin
      step();
      chk("t1_out", 32'(b16.out), 32'(i % 16));
      chk("t1_max", 32'(b16.at_max), 32'((i % 16) == 15));
      chk("t1_ovf", 32'(b16.ovf), 32'(i >= 16));
    end
    b16.en = 0;

    // 2: mod-10 wrap up then down
    b10w.load = 1; b10w.load_val = 4'd9;
    step();
    b10w.load = 0;
    chk("t2_load", 32'(b10w.out), 9);
    chk("t2_max", 32'(b10w.at_max), 1);
    chk("t2_ovf0", 32'(b10w.ovf), 0);
    b10w.en = 1; b10w.up = 1;
    step();
    chk("t2_wrapup", 32'(b10w.out), 0);
    chk("t2_ovf", 32'(b10w.ovf), 1);
    chk("t2_min", 32'(b10w.at_min), 1);
    b10w.up = 0;
    step();
    chk("t2_wrapdn", 32'(b10w.out), 9);
    b10w.en = 0;

    // 3: mod-10 saturate, clamped load
    b10s.load = 1; b10s.load_val = 4'd12;
    step();
    b10s.load = 0;
    chk("t3_clamp", 32'(b10s.out), 9);
    chk("t3_ovf0", 32'(b10s.ovf), 0);
    b10s.en = 1; b10s.up = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold", 32'(b10s.out), 9);
      chk("t3_ovf", 32'(b10s.ovf), 1);
    end
    b10s.en = 0; b10s.load = 1; b10s.load_val = 4'd0;
    step();
    chk("t3_load0", 32'(b10s.out), 0);
    b10s.load = 0; b10s.en = 1; b10s.up = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t3_holdlo", 32'(b10s.out), 0);
      chk("t3_min", 32'(b10s.at_min), 1);
    end
    b10s.en = 0;

    // 4: priority (u16 ovf is 1 from test 1)
    b16.clear = 1; b16.load = 1; b16.load_val = 4'd5; b16.en = 1; b16.up = 1;
    step();
    chk("t4_clr_out", 32'(b16.out), 0);
    chk("t4_clr_ovf", 32'(b16.ovf), 0);
    b16.clear = 0;
    step();
    chk("t4_load_en", 32'(b16.out), 5);
    b16.load = 0; b16.en = 0;

    // 5: reset mid-count with ovf set
    b16.load = 1; b16.load_val = 4'd15;
    step();
    b16.load = 0; b16.en = 1; b16.up = 1;
    step();
    chk("t5_wrap", 32'(b16.out), 0);
    chk("t5_ovf1", 32'(b16.ovf), 1);
    for (int i = 0; i < 7; i++) step();
    chk("t5_at7", 32'(b16.out), 7);
    reset_n = 1'b0;
    step();
    chk("t5_rst_out", 32'(b16.out), 0);
    chk("t5_rst_ovf", 32'(b16.ovf), 0);
    reset_n = 1'b1;
    step();
    chk("t5_res1", 32'(b16.out), 1);
    step();
    chk("t5_res2", 32'(b16.out), 2);
    b16.en = 0;

    // 6: en low, up/load_val wiggling mid-cycle must not disturb outputs
    for (int i = 0; i < 5; i++) begin
      step();
      b16.up = ~b16.up;
      b16.load_val = 4'(i * 3 + 1);
      #2;
      chk("t6_comb_out", 32'(b16.out), 2);
      chk("t6_comb_max", 32'(b16.at_max), 0);
      chk("t6_min", 32'(b16.at_min), 0);
      chk("t6_ovf", 32'(b16.ovf), 0);
    end
    step();
    chk("t6_end", 32'(b16.out), 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
